// File: rtl/w_ptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// w_ptr_full_ctrl
// Write-domain pointer and full-flag controller for an asynchronous FIFO.
// Keeps the binary write pointer, produces the memory write enable and the
// registered write address, and publishes a registered Gray write pointer
// for the read-domain synchronizer. From the already-synchronized Gray read
// pointer it derives registered full / almost-full flags, a fill level and
// a sticky overflow flag, all in the w_clk domain.
//
// Ports
//   w_clk          in   write-domain clock
//   w_rst_n        in   asynchronous active-low reset
//   w_inc          in   producer write request
//   sync_gr_r_ptr  in   Gray read pointer, synchronized into w_clk
//   w_ovf_clr      in   synchronous clear of w_overflow
//   w_en           out  memory write enable (combinational)
//   w_addr         out  registered memory write address
//   gr_w_ptr       out  registered Gray write pointer (crosses domains)
//   w_full         out  registered full flag
//   w_almost_full  out  registered level >= AFULL_THRESH
//   w_level        out  registered fill level, 0..2^ADDR_WIDTH
//   w_overflow     out  sticky: write attempted while full
// -----------------------------------------------------------------------------
module w_ptr_full_ctrl #(
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic                  w_inc,
    input  logic [ADDR_WIDTH:0]   sync_gr_r_ptr,
    input  logic                  w_ovf_clr,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH:0]   gr_w_ptr,
    output logic                  w_full,
    output logic                  w_almost_full,
    output logic [ADDR_WIDTH:0]   w_level,
    output logic                  w_overflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_TH = PW'(AFULL_THRESH);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0]         wb_q,    wb_d;
    logic [PW-1:0]         gr_q,    gr_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  full_q,  full_d;
    logic                  afull_q, afull_d;
    logic [PW-1:0]         level_q, level_d;
    logic                  ovf_q,   ovf_d;
    logic [PW-1:0]         rb_s;
    logic [PW-1:0]         full_cmp_s;

    assign w_en = w_inc & ~full_q;

    // Next-state computation: pointer advance, flags and level for this edge.
    always_comb begin
        wb_d       = wb_q + {{ADDR_WIDTH{1'b0}}, w_en};
        gr_d       = bin2gray(wb_d);
        addr_d     = wb_d[ADDR_WIDTH-1:0];
        rb_s       = gray2bin(sync_gr_r_ptr);
        // Full when the write pointer is one lap ahead: in Gray that means
        // the top two bits differ and the remaining bits match.
        full_cmp_s = {~sync_gr_r_ptr[ADDR_WIDTH:ADDR_WIDTH-1],
                      sync_gr_r_ptr[ADDR_WIDTH-2:0]};
        full_d     = (gr_d == full_cmp_s);
        // Modulo subtraction keeps the level correct across pointer wrap.
        level_d    = wb_d - rb_s;
        afull_d    = (level_d >= AFULL_TH);
        // A new overflow takes priority over a simultaneous clear.
        if (w_inc && full_q) begin
            ovf_d = 1'b1;
        end else if (w_ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            wb_q    <= {PW{1'b0}};
            gr_q    <= {PW{1'b0}};
            addr_q  <= {ADDR_WIDTH{1'b0}};
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            level_q <= {PW{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            wb_q    <= wb_d;
            gr_q    <= gr_d;
            addr_q  <= addr_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign w_addr        = addr_q;
    assign gr_w_ptr      = gr_q;
    assign w_full        = full_q;
    assign w_almost_full = afull_q;
    assign w_level       = level_q;
    assign w_overflow    = ovf_q;

endmodule

// File: tb/tb_w_ptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// tb_w_ptr_full_ctrl
// Directed self-checking bench for w_ptr_full_ctrl (ADDR_WIDTH=3,
// AFULL_THRESH=6). Inputs change 1 ns after the rising edge and outputs
// are sampled at that point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_w_ptr_full_ctrl;

    logic       w_clk;
    logic       w_rst_n;
    logic       w_inc;
    logic [3:0] sync_gr_r_ptr;
    logic       w_ovf_clr;
    logic       w_en;
    logic [2:0] w_addr;
    logic [3:0] gr_w_ptr;
    logic       w_full;
    logic       w_almost_full;
    logic [3:0] w_level;
    logic       w_overflow;

    int tests = 0;
    int fails = 0;

    w_ptr_full_ctrl #(
        .ADDR_WIDTH  (3),
        .AFULL_THRESH(6)
    ) dut (
        .w_clk        (w_clk),
        .w_rst_n      (w_rst_n),
        .w_inc        (w_inc),
        .sync_gr_r_ptr(sync_gr_r_ptr),
        .w_ovf_clr    (w_ovf_clr),
        .w_en         (w_en),
        .w_addr       (w_addr),
        .gr_w_ptr     (gr_w_ptr),
        .w_full       (w_full),
        .w_almost_full(w_almost_full),
        .w_level      (w_level),
        .w_overflow   (w_overflow)
    );

    initial begin
        w_clk = 1'b0;
        forever #5 w_clk = ~w_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  {29'd0, w_addr},   32'd0);
        chk({tag, "_gr"},    {28'd0, gr_w_ptr}, 32'd0);
        chk({tag, "_level"}, {28'd0, w_level},  32'd0);
        chk({tag, "_full"},  {31'd0, w_full},   32'd0);
        chk({tag, "_afull"}, {31'd0, w_almost_full}, 32'd0);
        chk({tag, "_ovf"},   {31'd0, w_overflow}, 32'd0);
    endtask

    logic [3:0] gexp [8];
    logic [3:0] m_wb, m_rb, m_lvl, prev_gr, cnt;
    logic       m_full, acc;
    int         adv;
    bit         wrapped;

    initial begin
        gexp = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

        // ---- reset with w_inc high ----
        w_rst_n = 1'b0; w_inc = 1'b1; sync_gr_r_ptr = 4'd0; w_ovf_clr = 1'b0;
        #3;
        chk_all_zero("rst");
        chk("rst_wen", {31'd0, w_en}, 32'd1);
        tick();
        chk_all_zero("rst_edge");
        w_inc = 1'b0;
        #3 w_rst_n = 1'b1;
        tick();
        chk("post_rst_addr", {29'd0, w_addr},   32'd0);
        chk("post_rst_gr",   {28'd0, gr_w_ptr}, 32'd0);

        // ---- fill: 8 writes, read pointer held at 0 ----
        w_inc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("fill_wen_%0d", i), {31'd0, w_en}, 32'd1);
            tick();
            chk($sformatf("fill_gr_%0d", i),    {28'd0, gr_w_ptr}, {28'd0, gexp[i]});
            chk($sformatf("fill_addr_%0d", i),  {29'd0, w_addr},   32'((i + 1) % 8));
            chk($sformatf("fill_lvl_%0d", i),   {28'd0, w_level},  32'(i + 1));
            chk($sformatf("fill_afull_%0d", i), {31'd0, w_almost_full}, (i >= 5) ? 32'd1 : 32'd0);
            chk($sformatf("fill_full_%0d", i),  {31'd0, w_full},   (i == 7) ? 32'd1 : 32'd0);
        end

        // ---- overflow: keep writing while full ----
        #1 chk("ovf_wen", {31'd0, w_en}, 32'd0);
        tick();
        chk("ovf_flag", {31'd0, w_overflow}, 32'd1);
        chk("ovf_gr",   {28'd0, gr_w_ptr},   32'hC);
        chk("ovf_addr", {29'd0, w_addr},     32'd0);
        chk("ovf_lvl",  {28'd0, w_level},    32'd8);
        chk("ovf_full", {31'd0, w_full},     32'd1);

        w_inc = 1'b0; w_ovf_clr = 1'b1;
        tick();
        chk("ovf_clr", {31'd0, w_overflow}, 32'd0);

        w_inc = 1'b1; w_ovf_clr = 1'b1;
        tick();
        chk("ovf_set_wins", {31'd0, w_overflow}, 32'd1);
        w_inc = 1'b0; w_ovf_clr = 1'b0;

        // ---- read release: read pointer binary 3 ----
        sync_gr_r_ptr = 4'b0010;
        tick();
        chk("rel_full",  {31'd0, w_full},        32'd0);
        chk("rel_lvl",   {28'd0, w_level},       32'd5);
        chk("rel_afull", {31'd0, w_almost_full}, 32'd0);
        chk("rel_ovf",   {31'd0, w_overflow},    32'd1);

        // ---- mid-operation asynchronous reset at level 5 ----
        #2 w_rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        sync_gr_r_ptr = 4'd0;
        #3 w_rst_n = 1'b1;

        // ---- wrap/stress: 40 write requests, trailing read pointer ----
        m_wb = 4'd0; m_rb = 4'd0; m_full = 1'b0; wrapped = 1'b0;
        prev_gr = 4'd0;
        w_inc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cnt = m_wb - m_rb;
            adv = $urandom_range(0, (cnt > 4'd0) ? 1 : 0);
            m_rb = m_rb + 4'(adv);
            sync_gr_r_ptr = gray(m_rb);
            acc = ~m_full;
            if (acc && m_wb == 4'hF) wrapped = 1'b1;
            m_wb = m_wb + {3'd0, acc};
            m_lvl = m_wb - m_rb;
            m_full = (m_lvl == 4'd8);
            tick();
            chk($sformatf("st_lvl_%0d", i),  {28'd0, w_level},  {28'd0, m_lvl});
            chk($sformatf("st_full_%0d", i), {31'd0, w_full},   {31'd0, m_full});
            chk($sformatf("st_gr_%0d", i),   {28'd0, gr_w_ptr}, {28'd0, gray(m_wb)});
            chk($sformatf("st_step_%0d", i), 32'($countones(gr_w_ptr ^ prev_gr)), {31'd0, acc});
            prev_gr = gr_w_ptr;
        end
        chk("st_wrapped", {31'd0, wrapped}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/w_ptr_full_ctrl.md
# w_ptr_full_ctrl

Write-domain pointer and full-flag controller for the asynchronous FIFO. It takes write requests from the producer and generates the memory write enable and binary write address. It also produces the Gray-coded write pointer that crosses into the read domain. It consumes the two-flop-synchronized Gray read pointer and derives a registered full flag, an almost-full flag, a fill level and a sticky overflow flag, all in the w_clk domain.

## Interface
- ADDR_WIDTH, 3, memory address width; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, 6, fill level at or above which w_almost_full asserts; legal range 1..2^ADDR_WIDTH.

- w_clk  input  1  write-domain clock.
- w_rst_n  input  1  reset, asynchronous, active-low.
- w_inc  input  1  producer write request, sampled on rising w_clk.
- sync_gr_r_ptr  input  ADDR_WIDTH+1  Gray read pointer, already synchronized into w_clk domain.
- w_ovf_clr  input  1  synchronous clear of w_overflow.
- w_en  output  1  memory write enable, combinational: w_inc & ~w_full.
- w_addr  output  ADDR_WIDTH  memory write address, registered: low bits of binary write pointer.
- gr_w_ptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
- w_full  output  1  registered full flag.
- w_almost_full  output  1  registered, level ≥ AFULL_THRESH.
- w_level  output  ADDR_WIDTH+1  registered fill level, 0..2^ADDR_WIDTH.
- w_overflow  output  1  sticky flag; a write was attempted while full.

## Operation
- State: binary write pointer wb (ADDR_WIDTH+1 bits), wrapping modulo 2^(ADDR_WIDTH+1).
- wb_next = wb + (w_inc & ~w_full). gr_next = wb_next ^ (wb_next >> 1).
- On each rising edge: wb ← wb_next; gr_w_ptr ← gr_next; w_addr ← wb_next[ADDR_WIDTH-1:0].
- Full: w_full ← (gr_next == {~sync_gr_r_ptr[ADDR_WIDTH:ADDR_WIDTH-1], sync_gr_r_ptr[ADDR_WIDTH-2:0]}).
- Read pointer decode: rb is the combinational Gray-to-binary conversion of sync_gr_r_ptr (rb[i] = XOR of sync_gr_r_ptr[ADDR_WIDTH:i]).
- Level: w_level ← (wb_next − rb) mod 2^(ADDR_WIDTH+1).
- Almost full: w_almost_full ← ((wb_next − rb) ≥ AFULL_THRESH).
- Overflow:
  - w_overflow ← 1 when w_inc & w_full.
  - Otherwise w_overflow ← 0 when w_ovf_clr.
  - Set wins over a simultaneous clear.
- A rejected write (w_inc while w_full) does not change any pointer, level or address.
- The flags are pessimistic: the synchronized read pointer lags by two or more w_clk cycles, so w_full, w_almost_full and w_level can over-report but never under-report. Only gr_w_ptr crosses domains. It changes by exactly one bit per accepted write.

## Timing
- Reset (asynchronous, immediate):
  - wb, gr_w_ptr, w_addr, w_level = 0.
  - w_full, w_almost_full, w_overflow = 0.
  - w_en then follows w_inc.
- A write is accepted on the edge where w_en=1. The memory captures data at the current w_addr on that edge, and w_addr advances on the same edge.
- The flags and level reflect the accepted write on the same edge, i.e. one register stage with no extra latency. The write that fills the FIFO sets w_full on its own edge.
- A change on sync_gr_r_ptr is reflected in w_full, w_level and w_almost_full on the next rising edge.
- Wrap-around: after wb = 2^(ADDR_WIDTH+1)−1 the next accepted write gives wb = 0; the level arithmetic stays correct across the wrap.
- A read-pointer advance and an accepted write on the same edge are both reflected in that edge's level and flags.
- Reset asserted mid-operation clears everything asynchronously; pointer contents are lost.

## Test plan
- Reset values: assert w_rst_n=0 with w_inc=1 -> all registered outputs 0; w_en=1; after release, w_addr=0 and gr_w_ptr=0.
- Gray sequence, ADDR_WIDTH=3, sync_gr_r_ptr held 0: 8 writes -> gr_w_ptr = 1,3,2,6,7,5,4,C.
  - w_addr = 1..7,0 (wrapped).
  - w_full=1 on the 8th edge with w_level=8; w_almost_full=1 from the 6th edge.
- Overflow: continue w_inc=1 while full -> w_en=0, pointers unchanged, w_overflow=1.
  - Pulse w_ovf_clr with w_inc=0 -> w_overflow=0 next edge.
  - Clear and overflow on the same edge -> w_overflow stays 1.
- Read release: from full, drive sync_gr_r_ptr=4'b0010 (binary 3) -> next edge w_full=0, w_level=5, w_almost_full=0.
- Wrap/stress: 40 writes with the model read pointer trailing by 0–8 entries (gray-coded) -> w_level always equals the model count.
  - w_full exactly when the count is 8; gr_w_ptr changes by one bit per write; the pointer wraps 16→0 cleanly.
- Mid-operation reset: assert w_rst_n low asynchronously between edges at level 5 -> outputs clear immediately without waiting for a clock edge.
